// File: rtl/ami.sv
// AXI4 master bridge: converts user burst commands into single-outstanding INCR
// write and read bursts, with independent write and read engines.
module ami #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AMI_ID     = 0,
    parameter int AXI_WSTRBW = AXI_DW / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // write address
    output logic [AXI_IW-1:0]     AWID,
    output logic [AXI_AW-1:0]     AWADDR,
    output logic [AXI_LW-1:0]     AWLEN,
    output logic [AXI_SW-1:0]     AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWLOCK,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic [3:0]            AWQOS,
    output logic [3:0]            AWREGION,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // write data
    output logic [AXI_DW-1:0]     WDATA,
    output logic [AXI_WSTRBW-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    // write response
    input  logic [AXI_IW-1:0]     BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // read address
    output logic [AXI_IW-1:0]     ARID,
    output logic [AXI_AW-1:0]     ARADDR,
    output logic [AXI_LW-1:0]     ARLEN,
    output logic [AXI_SW-1:0]     ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARLOCK,
    output logic [3:0]            ARCACHE,
    output logic [2:0]            ARPROT,
    output logic [3:0]            ARQOS,
    output logic [3:0]            ARREGION,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // read data
    input  logic [AXI_IW-1:0]     RID,
    input  logic [AXI_DW-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    // user write side
    input  logic                  usr_wcmd_valid,
    output logic                  usr_wcmd_ready,
    input  logic [AXI_AW-1:0]     usr_wcmd_addr,
    input  logic [AXI_LW-1:0]     usr_wcmd_len,
    input  logic [AXI_SW-1:0]     usr_wcmd_size,
    input  logic [AXI_DW-1:0]     usr_wdata,
    input  logic [AXI_WSTRBW-1:0] usr_wstrb,
    input  logic                  usr_wvalid,
    output logic                  usr_wready,
    output logic                  usr_wdone,
    output logic [1:0]            usr_wresp,
    // user read side
    input  logic                  usr_rcmd_valid,
    output logic                  usr_rcmd_ready,
    input  logic [AXI_AW-1:0]     usr_rcmd_addr,
    input  logic [AXI_LW-1:0]     usr_rcmd_len,
    input  logic [AXI_SW-1:0]     usr_rcmd_size,
    output logic [AXI_DW-1:0]     usr_rdata,
    output logic                  usr_rlast,
    output logic                  usr_rvalid,
    input  logic                  usr_rready,
    output logic                  usr_rdone,
    output logic [1:0]            usr_rresp
);

    localparam logic [AXI_IW-1:0] ID     = AXI_IW'(AMI_ID);
    localparam int                SZ_MAX = $clog2(AXI_WSTRBW);
    localparam int                SPW    = AXI_LW + 1 + (2 ** AXI_SW);
    localparam int                EW     = SPW + 1;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    // Burst is illegal if beats are wider than the bus or the byte span crosses a 4KB page.
    function automatic logic cmd_err(input logic [11:0] off, input logic [AXI_LW-1:0] len,
                                     input logic [AXI_SW-1:0] size);
        logic [SPW-1:0] span;
        logic [EW-1:0]  end_addr;
        span     = SPW'({1'b0, len} + 1'b1) << size;
        end_addr = EW'(off) + EW'(span);
        return (size > AXI_SW'(SZ_MAX)) || (end_addr > EW'(4096));
    endfunction

    wstate_t           wstate, wstate_nx;
    rstate_t           rstate, rstate_nx;
    logic [AXI_LW-1:0] wcnt, rcnt;
    logic [AXI_AW-1:0] aw_addr, ar_addr;
    logic [AXI_LW-1:0] aw_len, ar_len;
    logic [AXI_SW-1:0] aw_size, ar_size;
    logic              wdone, rdone;
    logic [1:0]        wresp, rresp;
    logic [1:0]        racc, racc_nx, beat_resp;
    logic              wcmd_acc, rcmd_acc, werr, rerr, w_hs, r_hs;

    assign werr = cmd_err(usr_wcmd_addr[11:0], usr_wcmd_len, usr_wcmd_size);
    assign rerr = cmd_err(usr_rcmd_addr[11:0], usr_rcmd_len, usr_rcmd_size);

    assign AWID     = ID;
    assign AWADDR   = aw_addr;
    assign AWLEN    = aw_len;
    assign AWSIZE   = aw_size;
    assign AWBURST  = 2'b01;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'd0;
    assign AWPROT   = 3'd0;
    assign AWQOS    = 4'd0;
    assign AWREGION = 4'd0;
    assign WDATA    = usr_wdata;
    assign WSTRB    = usr_wstrb;

    assign ARID     = ID;
    assign ARADDR   = ar_addr;
    assign ARLEN    = ar_len;
    assign ARSIZE   = ar_size;
    assign ARBURST  = 2'b01;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'd0;
    assign ARPROT   = 3'd0;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;
    assign usr_rdata = RDATA;
    assign usr_rlast = RLAST;

    assign usr_wdone = wdone;
    assign usr_wresp = wresp;
    assign usr_rdone = rdone;
    assign usr_rresp = rresp;

    // Command ready is withheld during reset and for the cycle the done pulse is shown.
    always_comb begin
        wstate_nx      = wstate;
        usr_wcmd_ready = 1'b0;
        wcmd_acc       = 1'b0;
        AWVALID        = 1'b0;
        WVALID         = 1'b0;
        usr_wready     = 1'b0;
        WLAST          = 1'b0;
        BREADY         = 1'b0;
        w_hs           = 1'b0;
        case (wstate)
            W_IDLE: begin
                usr_wcmd_ready = ARESETn && !wdone;
                wcmd_acc       = usr_wcmd_valid && usr_wcmd_ready;
                if (wcmd_acc && !werr) wstate_nx = W_ADDR;
            end
            W_ADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) wstate_nx = W_DATA;
            end
            W_DATA: begin
                WVALID     = usr_wvalid;
                usr_wready = WREADY;
                WLAST      = (wcnt == aw_len);
                w_hs       = usr_wvalid && WREADY;
                if (w_hs && WLAST) wstate_nx = W_RESP;
            end
            W_RESP: begin
                BREADY = 1'b1;
                if (BVALID) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wstate  <= W_IDLE;
            wcnt    <= '0;
            aw_addr <= '0;
            aw_len  <= '0;
            aw_size <= '0;
            wdone   <= 1'b0;
            wresp   <= 2'b00;
        end else begin
            wstate <= wstate_nx;
            wdone  <= 1'b0;
            if (wcmd_acc) begin
                aw_addr <= usr_wcmd_addr;
                aw_len  <= usr_wcmd_len;
                aw_size <= usr_wcmd_size;
                wcnt    <= '0;
                if (werr) begin
                    wdone <= 1'b1;
                    wresp <= 2'b10;
                end
            end
            if (w_hs) wcnt <= wcnt + 1'b1;
            if (wstate == W_RESP && BVALID) begin
                wdone <= 1'b1;
                wresp <= (BID != ID) ? 2'b10 : BRESP;
            end
        end
    end

    // Early RLAST or a foreign RID is escalated to at least SLVERR.
    always_comb begin
        rstate_nx      = rstate;
        usr_rcmd_ready = 1'b0;
        rcmd_acc       = 1'b0;
        ARVALID        = 1'b0;
        RREADY         = 1'b0;
        usr_rvalid     = 1'b0;
        r_hs           = 1'b0;
        beat_resp      = RRESP;
        racc_nx        = racc;
        case (rstate)
            R_IDLE: begin
                usr_rcmd_ready = ARESETn && !rdone;
                rcmd_acc       = usr_rcmd_valid && usr_rcmd_ready;
                if (rcmd_acc && !rerr) rstate_nx = R_ADDR;
            end
            R_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) rstate_nx = R_DATA;
            end
            R_DATA: begin
                usr_rvalid = RVALID;
                RREADY     = usr_rready;
                r_hs       = RVALID && usr_rready;
                if ((RLAST && rcnt != ar_len) || RID != ID)
                    beat_resp = (RRESP > 2'b10) ? RRESP : 2'b10;
                racc_nx = (beat_resp > racc) ? beat_resp : racc;
                if (r_hs && RLAST) rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rstate  <= R_IDLE;
            rcnt    <= '0;
            racc    <= 2'b00;
            ar_addr <= '0;
            ar_len  <= '0;
            ar_size <= '0;
            rdone   <= 1'b0;
            rresp   <= 2'b00;
        end else begin
            rstate <= rstate_nx;
            rdone  <= 1'b0;
            if (rcmd_acc) begin
                ar_addr <= usr_rcmd_addr;
                ar_len  <= usr_rcmd_len;
                ar_size <= usr_rcmd_size;
                rcnt    <= '0;
                racc    <= 2'b00;
                if (rerr) begin
                    rdone <= 1'b1;
                    rresp <= 2'b10;
                end
            end
            if (r_hs) begin
                rcnt <= rcnt + 1'b1;
                racc <= racc_nx;
                if (RLAST) begin
                    rdone <= 1'b1;
                    rresp <= racc_nx;
                end
            end
        end
    end

endmodule
